// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC arbiter: command layout, FSM encoding and pack/unpack helpers.
package cordic_arb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ANGLE_W  = 16;
  localparam int unsigned STAGES_W = 16;

  // Field offsets for the default widths, LSB first.
  localparam int unsigned MR_EXT_VLD_OFS    = 0;
  localparam int unsigned ANGLE_MR_N_OFS    = MR_EXT_VLD_OFS + 1;
  localparam int unsigned MICRO_ROT_OFS     = ANGLE_MR_N_OFS + 1;
  localparam int unsigned ANGLE_OFS         = MICRO_ROT_OFS + STAGES_W;
  localparam int unsigned ROT_Y_OFS         = ANGLE_OFS + ANGLE_W;
  localparam int unsigned ROT_X_OFS         = ROT_Y_OFS + DATA_W;
  localparam int unsigned QUAD_OFS          = ROT_X_OFS + DATA_W;
  localparam int unsigned ANGLE_CALC_EN_OFS = QUAD_OFS + 2;
  localparam int unsigned VEC_Y_OFS         = ANGLE_CALC_EN_OFS + 1;
  localparam int unsigned VEC_X_OFS         = VEC_Y_OFS + DATA_W;
  localparam int unsigned ROT_EN_OFS        = VEC_X_OFS + DATA_W;
  localparam int unsigned VEC_EN_OFS        = ROT_EN_OFS + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                vec_en;
    logic                rot_en;
    logic [DATA_W-1:0]   vec_x;
    logic [DATA_W-1:0]   vec_y;
    logic                angle_calc_en;
    logic [1:0]          quad;
    logic [DATA_W-1:0]   rot_x;
    logic [DATA_W-1:0]   rot_y;
    logic [ANGLE_W-1:0]  angle;
    logic [STAGES_W-1:0] micro_rot;
    logic                angle_micro_rot_n;
    logic                micro_rot_ext_vld;
  } cordic_cmd_t;

  localparam int unsigned CMD_W = $bits(cordic_cmd_t);

  function automatic int unsigned cmd_width(int unsigned dw, int unsigned aw, int unsigned sw);
    return 4 * dw + aw + sw + 7;
  endfunction

  function automatic logic [CMD_W-1:0] cmd_pack(cordic_cmd_t c);
    return c;
  endfunction

  function automatic cordic_cmd_t cmd_unpack(logic [CMD_W-1:0] v);
    return cordic_cmd_t'(v);
  endfunction

  function automatic int unsigned rr_wrap(int unsigned v, int unsigned n);
    return v % n;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr, wrapping.
module rr_pick
  import cordic_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c
);

  // Scan from farthest to nearest so the nearest requester above ptr wins.
  always_comb begin
    idx_c = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      if (req[rr_wrap(32'(ptr) + k, N)]) idx_c = IW'(rr_wrap(32'(ptr) + k, N));
    end
    gnt_c = (|req) ? (N'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter and registered command mux in front of the shared CORDIC core.
// Optional watchdog release enabled by CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS    = 4,
  parameter  int unsigned DATA_WIDTH     = DATA_W,
  parameter  int unsigned ANGLE_WIDTH    = ANGLE_W,
  parameter  int unsigned CORDIC_STAGES  = STAGES_W,
  parameter  int unsigned FLUSH_CYCLES   = 2,
`ifdef CORDIC_ARB_TIMEOUT_EN
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
`endif
  localparam int unsigned CMD_WIDTH      = cmd_width(DATA_WIDTH, ANGLE_WIDTH, CORDIC_STAGES),
  localparam int unsigned IDX_W          = $clog2(NUM_CLIENTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CLIENTS-1:0]           cli_req,
  input  logic [NUM_CLIENTS-1:0]           cli_release,
  input  logic [NUM_CLIENTS*CMD_WIDTH-1:0] cli_cmd,
  output logic [NUM_CLIENTS-1:0]           cli_gnt,
  output logic [NUM_CLIENTS-1:0]           cli_rsp_vld,
  input  logic                             cordic_out_vld,
  output logic [CMD_WIDTH-1:0]             cordic_cmd,
  output logic                             cordic_nreset,
  output logic                             busy
`ifdef CORDIC_ARB_TIMEOUT_EN
  , output logic                           timeout_err
`endif
);

  localparam int unsigned FLUSH_W = 4;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d, rr_q, rr_d, pick_idx;
  logic [NUM_CLIENTS-1:0] owner_oh_q, owner_oh_d, pick_gnt, gnt_d;
  logic [FLUSH_W-1:0]     flush_q, flush_d;
  logic [CMD_WIDTH-1:0]   cmd_d;
  logic                   leave;
  logic [CMD_WIDTH-1:0]   cmd_arr [NUM_CLIENTS];

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_d;
`endif

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cmd
    assign cmd_arr[i] = cli_cmd[i*CMD_WIDTH +: CMD_WIDTH];
  end

  rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .req   (cli_req),
    .ptr   (rr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx)
  );

  // Results go only to the current owner; gnt is zero outside BUSY.
  assign cli_rsp_vld = {NUM_CLIENTS{cordic_out_vld}} & cli_gnt;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    rr_d       = rr_q;
    flush_d    = flush_q;
    leave      = 1'b0;
    gnt_d      = '0;
    cmd_d      = '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    to_cnt_d   = '0;
    to_err_d   = timeout_err;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|cli_req) begin
          state_d    = ST_FLUSH;
          owner_d    = pick_idx;
          owner_oh_d = pick_gnt;
          flush_d    = FLUSH_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        flush_d = flush_q - FLUSH_W'(1);
        if (flush_q == FLUSH_W'(1)) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        leave = cli_release[owner_q];
`ifdef CORDIC_ARB_TIMEOUT_EN
        // Idle-owner watchdog: any CORDIC result restarts the count.
        if (!cordic_out_vld) to_cnt_d = to_cnt_q + TO_W'(1);
        if (!cordic_out_vld && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          leave    = 1'b1;
          to_err_d = 1'b1;
        end
`endif
        if (leave) begin
          state_d = ST_IDLE;
          rr_d    = owner_q;
        end else begin
          cmd_d = cmd_arr[owner_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_BUSY) gnt_d = owner_oh_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      owner_oh_q    <= '0;
      rr_q          <= '0;
      flush_q       <= '0;
      cli_gnt       <= '0;
      cordic_cmd    <= '0;
      cordic_nreset <= 1'b0;
      busy          <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      owner_oh_q    <= owner_oh_d;
      rr_q          <= rr_d;
      flush_q       <= flush_d;
      cli_gnt       <= gnt_d;
      cordic_cmd    <= cmd_d;
      cordic_nreset <= (state_d != ST_FLUSH);
      busy          <= (state_d != ST_IDLE);
`ifdef CORDIC_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err   <= to_err_d;
`endif
    end
  end

endmodule
